// File: rtl/router_pkg.sv
// router_pkg: shared constants for the 1x3 packet router control path.
// Holds the FSM state encodings, the invalid destination address and the
// state register width.
package router_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] DECODE_ADDRESS     = 3'b000;
    localparam logic [STATE_W-1:0] LOAD_FIRST_DATA    = 3'b001;
    localparam logic [STATE_W-1:0] LOAD_DATA          = 3'b010;
    localparam logic [STATE_W-1:0] WAIT_TILL_EMPTY    = 3'b011;
    localparam logic [STATE_W-1:0] CHECK_PARITY_ERROR = 3'b100;
    localparam logic [STATE_W-1:0] LOAD_PARITY        = 3'b101;
    localparam logic [STATE_W-1:0] FIFO_FULL_STATE    = 3'b110;
    localparam logic [STATE_W-1:0] LOAD_AFTER_FULL    = 3'b111;

    localparam logic [1:0] ADDR_INVALID = 2'b11;

endpackage

// File: rtl/router_fsm.sv
// router_fsm: control FSM of the 1x3 packet router.
// Decodes the header destination, sequences header/payload/parity loading,
// and handles FIFO-full back-pressure and soft resets from the synchronizer.
// All outputs decode the registered state only (Moore machine).
// Optional build macro: ROUTER_FSM_STATE_OUT_EN adds output state_dbg[2:0],
// a copy of the registered state.
module router_fsm
    import router_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_packet_valid,
    output logic       write_enb_reg,
    output logic       detect_add,
    output logic       ld_state,
    output logic       laf_state,
    output logic       lfd_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       busy
`ifdef ROUTER_FSM_STATE_OUT_EN
    ,
    output logic [2:0] state_dbg
`endif
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;
    logic [1:0]         addr_q;
    logic               empty_hdr;
    logic               empty_q;
    logic               soft_hit;

    // Empty flag of the FIFO named by the incoming header byte
    always_comb begin
        empty_hdr = 1'b0;
        case (data_in)
            2'd0:    empty_hdr = fifo_empty_0;
            2'd1:    empty_hdr = fifo_empty_1;
            2'd2:    empty_hdr = fifo_empty_2;
            default: empty_hdr = 1'b0;
        endcase
    end

    // Empty flag and soft-reset request of the FIFO latched in addr_q
    always_comb begin
        empty_q  = 1'b0;
        soft_hit = 1'b0;
        case (addr_q)
            2'd0: begin
                empty_q  = fifo_empty_0;
                soft_hit = soft_reset_0;
            end
            2'd1: begin
                empty_q  = fifo_empty_1;
                soft_hit = soft_reset_1;
            end
            2'd2: begin
                empty_q  = fifo_empty_2;
                soft_hit = soft_reset_2;
            end
            default: begin
                empty_q  = 1'b0;
                soft_hit = 1'b0;
            end
        endcase
    end

    // Latch a valid destination while decoding the header
    always_ff @(posedge clock) begin
        if (resetn) begin
            addr_q <= '0;
        end else if (state == DECODE_ADDRESS && pkt_valid && data_in != ADDR_INVALID) begin
            addr_q <= data_in;
        end
    end

    // Next-state logic for normal packet sequencing
    always_comb begin
        state_next = state;
        case (state)
            DECODE_ADDRESS: begin
                if (pkt_valid && data_in != ADDR_INVALID) begin
                    state_next = empty_hdr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA:    state_next = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)       state_next = FIFO_FULL_STATE;
                else if (!pkt_valid) state_next = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) state_next = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)           state_next = DECODE_ADDRESS;
                else if (low_packet_valid) state_next = LOAD_PARITY;
                else                       state_next = LOAD_DATA;
            end
            LOAD_PARITY:        state_next = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            WAIT_TILL_EMPTY: begin
                if (empty_q) state_next = LOAD_FIRST_DATA;
            end
            default:            state_next = DECODE_ADDRESS;
        endcase
    end

    // State register: hard reset, then soft reset, then normal transitions
    always_ff @(posedge clock) begin
        if (resetn) begin
            state <= DECODE_ADDRESS;
        end else if (soft_hit) begin
            state <= DECODE_ADDRESS;
        end else begin
            state <= state_next;
        end
    end

    assign detect_add    = (state == DECODE_ADDRESS);
    assign lfd_state     = (state == LOAD_FIRST_DATA);
    assign ld_state      = (state == LOAD_DATA);
    assign laf_state     = (state == LOAD_AFTER_FULL);
    assign full_state    = (state == FIFO_FULL_STATE);
    assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
    assign write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                           (state == LOAD_AFTER_FULL);
    assign busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));

`ifdef ROUTER_FSM_STATE_OUT_EN
    assign state_dbg = state;
`endif

endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm: self-checking bench for router_fsm.
// Directed scenarios follow the router packet flows; a randomized phase is
// checked every cycle against a behavioural model of the transition rules.
module tb_router_fsm;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done;
    logic       low_packet_valid;
    logic       write_enb_reg, detect_add, ld_state, laf_state;
    logic       lfd_state, full_state, rst_int_reg, busy;
`ifdef ROUTER_FSM_STATE_OUT_EN
    logic [2:0] state_dbg;
`endif

    router_fsm dut (
        .clock            (clock),
        .resetn           (resetn),
        .pkt_valid        (pkt_valid),
        .data_in          (data_in),
        .fifo_full        (fifo_full),
        .fifo_empty_0     (fifo_empty_0),
        .fifo_empty_1     (fifo_empty_1),
        .fifo_empty_2     (fifo_empty_2),
        .soft_reset_0     (soft_reset_0),
        .soft_reset_1     (soft_reset_1),
        .soft_reset_2     (soft_reset_2),
        .parity_done      (parity_done),
        .low_packet_valid (low_packet_valid),
        .write_enb_reg    (write_enb_reg),
        .detect_add       (detect_add),
        .ld_state         (ld_state),
        .laf_state        (laf_state),
        .lfd_state        (lfd_state),
        .full_state       (full_state),
        .rst_int_reg      (rst_int_reg),
        .busy             (busy)
`ifdef ROUTER_FSM_STATE_OUT_EN
        ,
        .state_dbg        (state_dbg)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    typedef enum {S_DA, S_LFD, S_LD, S_WTE, S_CPE, S_LP, S_FFS, S_LAF} mst_t;

    mst_t       m_state;
    int         m_addr;
    logic [7:0] seen[$];

    // Expected output vector {detect_add,lfd,ld,laf,full,rst_int,write_enb,busy}
    function automatic logic [7:0] outs(mst_t s);
        case (s)
            S_DA:    return 8'b1000_0000;
            S_LFD:   return 8'b0100_0001;
            S_LD:    return 8'b0010_0010;
            S_LAF:   return 8'b0001_0011;
            S_FFS:   return 8'b0000_1001;
            S_CPE:   return 8'b0000_0101;
            S_LP:    return 8'b0000_0011;
            default: return 8'b0000_0001; // S_WTE
        endcase
    endfunction

    // Published 3-bit encoding of each state
    function automatic logic [2:0] enc(mst_t s);
        case (s)
            S_DA:    return 3'b000;
            S_LFD:   return 3'b001;
            S_LD:    return 3'b010;
            S_WTE:   return 3'b011;
            S_CPE:   return 3'b100;
            S_LP:    return 3'b101;
            S_FFS:   return 3'b110;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic [7:0] obs();
        return {detect_add, lfd_state, ld_state, laf_state,
                full_state, rst_int_reg, write_enb_reg, busy};
    endfunction

    function automatic logic empty_of(int a);
        logic [2:0] e;
        e = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
        return (a >= 0 && a < 3) ? e[a] : 1'b0;
    endfunction

    function automatic logic soft_of(int a);
        logic [2:0] s;
        s = {soft_reset_2, soft_reset_1, soft_reset_0};
        return (a >= 0 && a < 3) ? s[a] : 1'b0;
    endfunction

    // Behavioural model: apply the transition rules to the inputs seen at an edge
    task automatic model_step();
        mst_t nxt;
        int   naddr;
        int   d;
        d     = int'(data_in);
        nxt   = m_state;
        naddr = m_addr;
        if (resetn) begin
            m_state = S_DA;
            m_addr  = 0;
        end else begin
            if (m_state == S_DA && pkt_valid && d < 3) naddr = d;
            if (soft_of(m_addr)) begin
                nxt = S_DA;
            end else begin
                case (m_state)
                    S_DA:  if (pkt_valid && d < 3) nxt = empty_of(d) ? S_LFD : S_WTE;
                    S_LFD: nxt = S_LD;
                    S_LD:  nxt = fifo_full ? S_FFS : (!pkt_valid ? S_LP : S_LD);
                    S_FFS: nxt = fifo_full ? S_FFS : S_LAF;
                    S_LAF: nxt = parity_done ? S_DA : (low_packet_valid ? S_LP : S_LD);
                    S_LP:  nxt = S_CPE;
                    S_CPE: nxt = fifo_full ? S_FFS : S_DA;
                    S_WTE: nxt = empty_of(m_addr) ? S_LFD : S_WTE;
                    default: nxt = S_DA;
                endcase
            end
            m_state = nxt;
            m_addr  = naddr;
        end
    endtask

    // One clock: edge, model update, sample 1 time unit after the edge
    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        seen.push_back(obs());
    endtask

    task automatic clear_inputs();
        pkt_valid        = 1'b0;
        data_in          = 2'd0;
        fifo_full        = 1'b0;
        fifo_empty_0     = 1'b0;
        fifo_empty_1     = 1'b0;
        fifo_empty_2     = 1'b0;
        soft_reset_0     = 1'b0;
        soft_reset_1     = 1'b0;
        soft_reset_2     = 1'b0;
        parity_done      = 1'b0;
        low_packet_valid = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        resetn = 1'b1;
        cycle();
        resetn = 1'b0;
        seen.delete();
    endtask

    task automatic test_reset();
        clear_inputs();
        pkt_valid = 1'b1;
        fifo_full = 1'b1;
        resetn    = 1'b1;
        cycle();
        n_checks++;
        if (seen[0] !== outs(S_DA)) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, want %b", seen[0], outs(S_DA));
        end
`ifdef ROUTER_FSM_STATE_OUT_EN
        n_checks++;
        if (state_dbg !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_state_dbg: got %b, want 000", state_dbg);
        end
`endif
        resetn = 1'b0;
        clear_inputs();
        seen.delete();
    endtask

    task automatic test_basic_path();
        mst_t exp[$];
        apply_reset();
        fifo_empty_0 = 1'b1; pkt_valid = 1'b1; data_in = 2'd0;
        cycle(); exp.push_back(S_LFD);
        cycle(); exp.push_back(S_LD);
        cycle(); exp.push_back(S_LD);
        pkt_valid = 1'b0;
        cycle(); exp.push_back(S_LP);
        cycle(); exp.push_back(S_CPE);
        cycle(); exp.push_back(S_DA);
        foreach (exp[i]) begin
            n_checks++;
            if (seen[i] !== outs(exp[i])) begin
                n_fail++;
                $display("FAIL basic_path step %0d: got %b, want %b", i, seen[i], outs(exp[i]));
            end
        end
    endtask

    task automatic test_full_low_valid();
        mst_t exp[$];
        apply_reset();
        fifo_empty_0 = 1'b1; pkt_valid = 1'b1; data_in = 2'd0;
        cycle(); exp.push_back(S_LFD);
        cycle(); exp.push_back(S_LD);
        fifo_full = 1'b1; pkt_valid = 1'b0;   // full wins over end of packet
        cycle(); exp.push_back(S_FFS);
        cycle(); exp.push_back(S_FFS);
        fifo_full = 1'b0;
        cycle(); exp.push_back(S_LAF);
        low_packet_valid = 1'b1;
        cycle(); exp.push_back(S_LP);
        low_packet_valid = 1'b0;
        cycle(); exp.push_back(S_CPE);
        cycle(); exp.push_back(S_DA);
        foreach (exp[i]) begin
            n_checks++;
            if (seen[i] !== outs(exp[i])) begin
                n_fail++;
                $display("FAIL full_low_valid step %0d: got %b, want %b", i, seen[i], outs(exp[i]));
            end
        end
    endtask

    task automatic test_full_resume();
        mst_t exp[$];
        apply_reset();
        fifo_empty_0 = 1'b1; pkt_valid = 1'b1; data_in = 2'd0;
        cycle(); exp.push_back(S_LFD);
        cycle(); exp.push_back(S_LD);
        fifo_full = 1'b1;
        cycle(); exp.push_back(S_FFS);
        fifo_full = 1'b0;
        cycle(); exp.push_back(S_LAF);
        cycle(); exp.push_back(S_LD);
        pkt_valid = 1'b0;
        cycle(); exp.push_back(S_LP);
        cycle(); exp.push_back(S_CPE);
        cycle(); exp.push_back(S_DA);
        foreach (exp[i]) begin
            n_checks++;
            if (seen[i] !== outs(exp[i])) begin
                n_fail++;
                $display("FAIL full_resume step %0d: got %b, want %b", i, seen[i], outs(exp[i]));
            end
        end
    endtask

    task automatic test_parity_full();
        mst_t exp[$];
        apply_reset();
        fifo_empty_0 = 1'b1; pkt_valid = 1'b1; data_in = 2'd0;
        cycle(); exp.push_back(S_LFD);
        cycle(); exp.push_back(S_LD);
        pkt_valid = 1'b0;
        cycle(); exp.push_back(S_LP);
        fifo_full = 1'b1;
        cycle(); exp.push_back(S_CPE);
        cycle(); exp.push_back(S_FFS);
        fifo_full = 1'b0;
        cycle(); exp.push_back(S_LAF);
        parity_done = 1'b1;
        cycle(); exp.push_back(S_DA);
        parity_done = 1'b0;
        cycle(); exp.push_back(S_DA);
        foreach (exp[i]) begin
            n_checks++;
            if (seen[i] !== outs(exp[i])) begin
                n_fail++;
                $display("FAIL parity_full step %0d: got %b, want %b", i, seen[i], outs(exp[i]));
            end
        end
    endtask

    task automatic test_wait_and_soft_reset();
        mst_t exp[$];
        apply_reset();
        pkt_valid = 1'b1; data_in = 2'd1; fifo_empty_0 = 1'b1;
        cycle(); exp.push_back(S_WTE);
        cycle(); exp.push_back(S_WTE);
        fifo_empty_1 = 1'b1;
        cycle(); exp.push_back(S_LFD);
        cycle(); exp.push_back(S_LD);
        soft_reset_1 = 1'b1; pkt_valid = 1'b0;
        cycle(); exp.push_back(S_DA);
        soft_reset_1 = 1'b0; fifo_empty_1 = 1'b0; pkt_valid = 1'b1;
        cycle(); exp.push_back(S_WTE);
        pkt_valid = 1'b0; soft_reset_0 = 1'b1;   // other port's timeout is ignored
        cycle(); exp.push_back(S_WTE);
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b1;
        cycle(); exp.push_back(S_DA);
        soft_reset_1 = 1'b0;
        foreach (exp[i]) begin
            n_checks++;
            if (seen[i] !== outs(exp[i])) begin
                n_fail++;
                $display("FAIL wait_soft_reset step %0d: got %b, want %b", i, seen[i], outs(exp[i]));
            end
        end
    endtask

    task automatic test_invalid_addr_and_reset();
        mst_t exp[$];
        apply_reset();
        fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
        pkt_valid = 1'b1; data_in = 2'd3;
        cycle(); exp.push_back(S_DA);
        cycle(); exp.push_back(S_DA);
        data_in = 2'd2;
        cycle(); exp.push_back(S_LFD);
        cycle(); exp.push_back(S_LD);
        resetn = 1'b1;
        cycle(); exp.push_back(S_DA);
        resetn = 1'b0; pkt_valid = 1'b0;
        cycle(); exp.push_back(S_DA);
        foreach (exp[i]) begin
            n_checks++;
            if (seen[i] !== outs(exp[i])) begin
                n_fail++;
                $display("FAIL invalid_addr_reset step %0d: got %b, want %b", i, seen[i], outs(exp[i]));
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] got;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            resetn           = ($urandom_range(0, 79) == 0);
            pkt_valid        = ($urandom_range(0, 3) != 0);
            data_in          = 2'($urandom_range(0, 3));
            fifo_full        = ($urandom_range(0, 3) == 0);
            fifo_empty_0     = 1'($urandom_range(0, 1));
            fifo_empty_1     = 1'($urandom_range(0, 1));
            fifo_empty_2     = 1'($urandom_range(0, 1));
            soft_reset_0     = ($urandom_range(0, 29) == 0);
            soft_reset_1     = ($urandom_range(0, 29) == 0);
            soft_reset_2     = ($urandom_range(0, 29) == 0);
            parity_done      = ($urandom_range(0, 3) == 0);
            low_packet_valid = ($urandom_range(0, 2) == 0);
            cycle();
            got = seen[$];
            n_checks++;
            if (got !== outs(m_state)) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %b, want %b (model state %s)",
                         i, got, outs(m_state), m_state.name());
            end
`ifdef ROUTER_FSM_STATE_OUT_EN
            n_checks++;
            if (state_dbg !== enc(m_state)) begin
                n_fail++;
                $display("FAIL random_state_dbg cycle %0d: got %b, want %b", i, state_dbg, enc(m_state));
            end
`endif
        end
        resetn = 1'b0;
        clear_inputs();
    endtask

    initial begin
        m_state = S_DA;
        m_addr  = 0;
        resetn  = 1'b1;
        clear_inputs();
        test_reset();
        test_basic_path();
        test_full_low_valid();
        test_full_resume();
        test_parity_full();
        test_wait_and_soft_reset();
        test_invalid_addr_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
